// File: rtl/bypass_pkg.sv
// Shared defaults and the writeback history entry type for the bypass network.
// The entry fields are sized from the default widths, so the top's DATA_W and NREG must match them.
package bypass_pkg;
   localparam int DATA_W_DEF       = 16;
   localparam int NREG_DEF         = 16;
   localparam int DEPTH_DEF        = 3;
   localparam int NRD_DEF          = 2;
   localparam int MAX_INFLIGHT_DEF = 4;
   localparam int AW_DEF           = $clog2(NREG_DEF);

   typedef struct packed {
      logic                  valid;
      logic [AW_DEF-1:0]     rt;
      logic [DATA_W_DEF-1:0] data;
   } hist_entry_t;
endpackage

// File: rtl/pend_counter.sv
// Saturating per-register count of issued-but-not-written-back producers.
module pend_counter #(
   parameter int MAX = 4,
   parameter int CW  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          full
);
   assign full = (count == CW'(MAX));

   // Simultaneous inc and dec cancel; a writeback with nothing pending is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + CW'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/bypass_net.sv
// Operand forwarding from a short writeback history plus per-register pending-write hazard tracking.
// Optional BYPASS_STATS_EN adds saturating forward-hit and stall-cycle counters.
module bypass_net
   import bypass_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int NREG         = NREG_DEF,
   parameter int DEPTH        = DEPTH_DEF,
   parameter int NRD          = NRD_DEF,
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   localparam int AW          = $clog2(NREG),
   localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_rt,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rt,
   input  logic                  iss_wr,
   output logic                  iss_ready,
   input  logic [NRD*AW-1:0]     rd_addr,
   input  logic [NRD*DATA_W-1:0] rd_rf,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_hit,
   input  logic                  flush,
   output logic                  stall
`ifdef BYPASS_STATS_EN
   ,
   output logic [31:0]           fwd_hits,
   output logic [31:0]           stall_cycles
`endif
);
   localparam int NSLOT = 2 ** AW;

   hist_entry_t   hist [DEPTH];
   logic [CW-1:0] cnt  [NSLOT];
   logic [NSLOT-1:0] full;
   logic          wb_q;
   logic          iss_acc;

   assign wb_q    = wb_valid && (wb_rt != '0);
   assign iss_acc = iss_valid && iss_ready && !flush;

   // Register 0 and any address beyond NREG never accumulate pending writes.
   assign cnt[0]  = '0;
   assign full[0] = 1'b0;
   for (genvar r = 1; r < NSLOT; r++) begin : g_cnt
      if (r < NREG) begin : g_live
         pend_counter #(.MAX(MAX_INFLIGHT), .CW(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (iss_acc && iss_wr && (iss_rt == AW'(r))),
            .dec   (wb_q && (wb_rt == AW'(r))),
            .clr   (flush),
            .count (cnt[r]),
            .full  (full[r])
         );
      end else begin : g_none
         assign cnt[r]  = '0;
         assign full[r] = 1'b0;
      end
   end

   always_comb begin
      stall = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         if ((rd_addr[p*AW +: AW] != '0) && (cnt[rd_addr[p*AW +: AW]] != '0)) begin
            stall = 1'b1;
         end
      end
   end

   assign iss_ready = !stall && !(iss_wr && full[iss_rt]);

   // Oldest entry first so the youngest match is the one left standing.
   always_comb begin
      rd_data = '0;
      rd_hit  = '0;
      for (int p = 0; p < NRD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = rd_rf[p*DATA_W +: DATA_W];
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist[k].valid && (hist[k].rt == rd_addr[p*AW +: AW])) begin
               rd_data[p*DATA_W +: DATA_W] = hist[k].data;
               rd_hit[p]                   = 1'b1;
            end
         end
         if (rd_addr[p*AW +: AW] == '0) begin
            rd_data[p*DATA_W +: DATA_W] = '0;
            rd_hit[p]                   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            hist[k] <= '0;
         end
      end else if (wb_q) begin
         hist[0] <= '{valid: 1'b1, rt: wb_rt, data: wb_data};
         for (int k = 1; k < DEPTH; k++) begin
            hist[k] <= hist[k-1];
         end
      end
   end

`ifdef BYPASS_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_hits     <= '0;
         stall_cycles <= '0;
      end else begin
         if ((|rd_hit) && (fwd_hits != '1)) begin
            fwd_hits <= fwd_hits + 32'd1;
         end
         if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_bypass_net.sv
// Directed scoreboard bench for bypass_net: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_bypass_net;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_rt = '0;
   logic [15:0] wb_data = '0;
   logic        iss_valid = 1'b0;
   logic [3:0]  iss_rt = '0;
   logic        iss_wr = 1'b0;
   logic        iss_ready;
   logic [7:0]  rd_addr;
   logic [31:0] rd_rf;
   logic [31:0] rd_data;
   logic [1:0]  rd_hit;
   logic        flush = 1'b0;
   logic        stall;
   logic [3:0]  a0 = '0, a1 = '0;
   logic [15:0] rf0 = '0, rf1 = '0;
`ifdef BYPASS_STATS_EN
   logic [31:0] fwd_hits, stall_cycles;
`endif

   assign rd_addr = {a1, a0};
   assign rd_rf   = {rf1, rf0};

   always #5 clk = ~clk;

   bypass_net dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_rt(iss_rt), .iss_wr(iss_wr), .iss_ready(iss_ready),
      .rd_addr(rd_addr), .rd_rf(rd_rf), .rd_data(rd_data), .rd_hit(rd_hit),
      .flush(flush), .stall(stall)
`ifdef BYPASS_STATS_EN
      , .fwd_hits(fwd_hits), .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      string       nm;
      logic [15:0] d0;
      logic        h0;
      logic [15:0] d1;
      logic        h1;
      logic        st;
      logic        rdy;
   } exp_t;

   exp_t q[$];
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(string nm, string fld, logic [15:0] act, logic [15:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s.%s got %h want %h", nm, fld, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL monitor: observation with empty scoreboard");
         end else begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "rd_data0", rd_data[15:0], e.d0);
            cmp(e.nm, "rd_hit0", {15'd0, rd_hit[0]}, {15'd0, e.h0});
            cmp(e.nm, "rd_data1", rd_data[31:16], e.d1);
            cmp(e.nm, "rd_hit1", {15'd0, rd_hit[1]}, {15'd0, e.h1});
            cmp(e.nm, "stall", {15'd0, stall}, {15'd0, e.st});
            cmp(e.nm, "iss_ready", {15'd0, iss_ready}, {15'd0, e.rdy});
         end
      end
   end

   task automatic ex(string nm, logic [15:0] d0, logic h0, logic [15:0] d1, logic h1,
                     logic st, logic rdy);
      exp_t e;
      e = '{nm, d0, h0, d1, h1, st, rdy};
      q.push_back(e);
      chk_en = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk_en    = 1'b0;
      wb_valid  = 1'b0;
      iss_valid = 1'b0;
      iss_wr    = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic wb(logic [3:0] rt, logic [15:0] d);
      wb_valid = 1'b1; wb_rt = rt; wb_data = d;
   endtask

   task automatic iss(logic [3:0] rt);
      iss_valid = 1'b1; iss_rt = rt; iss_wr = 1'b1;
   endtask

   initial begin
      step();
      // Everything asserted while reset is low must be discarded.
      wb(4'd7, 16'h7070); iss(4'd7); flush = 1'b1;
      step();
      rst_n = 1'b1;

      a0 = 4'd7; rf0 = 16'h7777; rf1 = 16'h1F1F;
      ex("rst_prio", 16'h7777, 0, 16'h0000, 0, 0, 1); step();
      a0 = 4'd0; rf0 = 16'h5555;
      ex("rst_addr0", 16'h0000, 0, 16'h0000, 0, 0, 1); step();

      wb(4'd3, 16'h00AA); a0 = 4'd3; rf0 = 16'h1111;
      ex("same_cycle", 16'h1111, 0, 16'h0000, 0, 0, 1); step();
      ex("fwd_r3", 16'h00AA, 1, 16'h0000, 0, 0, 1); step();

      wb(4'd5, 16'h0001); a0 = 4'd0;
      ex("r5_w1", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      wb(4'd5, 16'h0002); a0 = 4'd5; rf0 = 16'h2222;
      ex("r5_w2", 16'h0001, 1, 16'h0000, 0, 0, 1); step();
      wb(4'd5, 16'h0003);
      ex("r5_w3", 16'h0002, 1, 16'h0000, 0, 0, 1); step();
      wb(4'd6, 16'h0066);
      ex("r5_young", 16'h0003, 1, 16'h0000, 0, 0, 1); step();
      wb(4'd7, 16'h0077);
      ex("r5_keep1", 16'h0003, 1, 16'h0000, 0, 0, 1); step();
      wb(4'd8, 16'h0088);
      ex("r5_keep2", 16'h0003, 1, 16'h0000, 0, 0, 1); step();
      wb(4'd9, 16'h0099);
      ex("r5_aged", 16'h2222, 0, 16'h0000, 0, 0, 1); step();
      a0 = 4'd7; a1 = 4'd8;
      ex("older_hit", 16'h0077, 1, 16'h0088, 1, 0, 1); step();

      a0 = 4'd0; a1 = 4'd0; iss(4'd4);
      ex("iss_r4", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      a0 = 4'd4; rf0 = 16'h4444; iss(4'd9);
      ex("stall_r4", 16'h4444, 0, 16'h0000, 0, 1, 0); step();
      wb(4'd4, 16'h0404);
      ex("wb_r4_same", 16'h4444, 0, 16'h0000, 0, 1, 0); step();
      a1 = 4'd9;
      ex("stall_clear", 16'h0404, 1, 16'h0099, 1, 0, 1); step();

      a0 = 4'd0; a1 = 4'd0;
      for (int i = 0; i < 4; i++) begin
         iss(4'd2);
         ex($sformatf("iss_r2_%0d", i), 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      end
      iss(4'd2);
      ex("r2_full", 16'h0000, 0, 16'h0000, 0, 0, 0); step();
      wb(4'd2, 16'h0202);
      ex("r2_wb", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      iss(4'd2); wb(4'd2, 16'h0222);
      ex("r2_iss_wb", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      iss(4'd2);
      ex("r2_to_full", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      iss(4'd2);
      ex("r2_full_again", 16'h0000, 0, 16'h0000, 0, 0, 0); step();
      iss(4'd10);
      ex("iss_r10", 16'h0000, 0, 16'h0000, 0, 0, 1); step();
      iss(4'd11);
      ex("iss_r11", 16'h0000, 0, 16'h0000, 0, 0, 1); step();

      flush = 1'b1; iss(4'd12); wb(4'd13, 16'h0D0D); a0 = 4'd2;
      ex("flush", 16'h0222, 1, 16'h0000, 0, 1, 0); step();
      a1 = 4'd10; rf1 = 16'hAAAA;
      ex("post_flush", 16'h0222, 1, 16'hAAAA, 0, 0, 1); step();
      a0 = 4'd13; a1 = 4'd12; rf1 = 16'hBBBB; iss_rt = 4'd2; iss_wr = 1'b1;
      ex("flush_iss_drop", 16'h0D0D, 1, 16'hBBBB, 0, 0, 1); step();

      a0 = 4'd0; rf0 = 16'h5A5A; a1 = 4'd11; rf1 = 16'hCCCC; wb(4'd0, 16'h0041);
      ex("wb_r0", 16'h0000, 0, 16'hCCCC, 0, 0, 1); step();
      wb(4'd0, 16'h0042);
      ex("wb_r0_b", 16'h0000, 0, 16'hCCCC, 0, 0, 1); step();
      a1 = 4'd2;
      ex("r0_no_hist", 16'h0000, 0, 16'h0222, 1, 0, 1); step();

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      a0 = 4'd13; rf0 = 16'hDDDD; a1 = 4'd2; rf1 = 16'hEEEE;
      ex("rst_clear", 16'hDDDD, 0, 16'hEEEE, 0, 0, 1); step();

      step();
      step();
      cmp("end", "queue_left", 16'(q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand/result width.
REQ-002 SHALL have parameter NREG, default 16: architectural registers; AW = clog2(NREG).
REQ-003 SHALL have parameter DEPTH, default 3 (1..8): writeback history entries available for forwarding.
REQ-004 SHALL have parameter NRD, default 2: operand read ports.
REQ-005 SHALL have parameter MAX_INFLIGHT, default 4: pending writes per register; CW = clog2(MAX_INFLIGHT+1).
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 synchronous active-low reset.
REQ-007 SHALL have ports: wb_valid in 1 writeback strobe; wb_rt in AW destination; wb_data in DATA_W result.
REQ-008 SHALL have ports: iss_valid in 1 issue attempt; iss_rt in AW destination; iss_wr in 1 issuing op writes a register; iss_ready out 1 issue accepted.
REQ-009 SHALL have ports: rd_addr in NRD*AW sources; rd_rf in NRD*DATA_W regfile data; rd_data out NRD*DATA_W forwarded operands; rd_hit out NRD forward taken.
REQ-010 SHALL have ports: flush in 1 squash in-flight ops; stall out 1 source hazard.

Function
REQ-011 SHALL hold a DEPTH-entry history {valid, rt, data}; on wb_valid with wb_rt!=0, entry 0 loads {1, wb_rt, wb_data} and entry k loads entry k-1; with no qualifying writeback the history holds.
REQ-012 SHALL drive rd_data[p] combinationally: 0 if rd_addr[p]==0; else data of the youngest valid entry matching rd_addr[p]; else rd_rf[p].
REQ-013 SHALL assert rd_hit[p] only when a history entry supplied rd_data[p].
REQ-014 SHALL not bypass same-cycle wb_data; a writeback is forwardable from the next cycle.
REQ-015 SHALL keep a CW-bit pending counter per register; +1 on accepted issue with iss_wr and iss_rt!=0, -1 on wb_valid with wb_rt!=0.
REQ-016 SHALL leave the counter unchanged when issue and writeback hit the same register in one cycle.
REQ-017 SHALL never decrement below 0: writeback to a register with count 0 is ignored by the counter but still enters history.
REQ-018 SHALL assert stall when any rd_addr[p]!=0 has pending count >0.
REQ-019 SHALL drive iss_ready = !stall && !(iss_wr && count[iss_rt]==MAX_INFLIGHT); issue is accepted only when iss_valid && iss_ready.
REQ-020 SHALL on flush clear all pending counters next edge, ignore any same-cycle issue, still record a same-cycle writeback in history.
REQ-021 SHALL treat register 0 as never pending and never recorded.

Reset
REQ-022 SHALL on rst_n low at clk edge clear all history valid bits, data and rt to 0, all counters to 0.
REQ-023 SHALL present after reset: stall=0, iss_ready=1, rd_hit=0, rd_data=rd_rf (0 for address 0).
REQ-024 SHALL give reset priority over flush, writeback and issue in the same cycle.

Configuration
REQ-025 SHALL, with BYPASS_STATS_EN defined, add output fwd_hits (32) counting cycles with any rd_hit set and output stall_cycles (32) counting cycles with stall set; both saturate at all-ones and reset to 0.
REQ-026 SHALL, without BYPASS_STATS_EN, omit both ports and counters; other behaviour identical.

Structure
REQ-027 SHALL place the history-entry typedef {valid, rt, data} and the default parameters in shared package bypass_pkg.
REQ-028 SHALL implement the per-register counter in sub-module pend_counter (inc, dec, clr, count, full), instantiated NREG-1 times.

Verification
REQ-029 SHALL test: wb r3=0x00AA, next cycle rd_addr0=3, rd_rf0=0x1111 -> rd_data0=0x00AA, rd_hit0=1.
REQ-030 SHALL test: wb r5=0x0001, 0x0002, 0x0003 on consecutive cycles -> rd_addr=5 yields 0x0003; DEPTH+1 unrelated writes later yields rd_rf.
REQ-031 SHALL test: issue r4 with iss_wr, next cycle rd_addr0=4 -> stall=1; wb r4 -> stall=0 the following cycle.
REQ-032 SHALL test: four issues to r2 (MAX_INFLIGHT=4) -> iss_ready=0 on fifth; issue+wb to r2 same cycle -> count unchanged.
REQ-033 SHALL test: three pending writes then flush -> all counters 0, stall=0 next cycle, history contents retained.
REQ-034 SHALL test: wb r0=0x0041, rd_addr0=0 -> rd_data0=0, rd_hit0=0, stall=0.
